// File: rtl/can_bit_destuffer.sv
// CAN bit-level front end clocked by the sample point: bus idle and SOF detection,
// removal of dynamic and FD fixed stuff bits, stuff error flagging and stuff count.
module can_bit_destuffer #(
  parameter int IDLE_BITS  = 11,
  parameter int STF_RUN    = 5,
  parameter int FIX_PERIOD = 4
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       STF_END,
  input  logic       FIX_STF,
  output logic       RX_D,
  output logic       STF_BIT,
  output logic       STF_ERR,
  output logic       BUS_IDLE,
  output logic       SOF,
  output logic [2:0] STF_CNT
);

  localparam logic [3:0] IDLE_LIM = 4'(IDLE_BITS);
  localparam logic [2:0] RUN_LIM  = 3'(STF_RUN);
  localparam logic [2:0] FIX_LIM  = 3'(FIX_PERIOD);

  typedef enum logic [2:0] {
    ST_WAIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_DYN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_OFF  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  state_t     state_r;
  logic [3:0] rec_cnt_r;
  logic [3:0] rec_nxt_s;
  logic [2:0] run_len_r;
  logic [2:0] fix_cnt_r;
  logic       last_r;
  logic       idle_hit_s;

  // Recessive run length including this bit, saturating at the idle threshold
  always_comb begin
    rec_nxt_s = 4'd0;
    if (!RX) begin
      rec_nxt_s = 4'd0;
    end else if (rec_cnt_r == IDLE_LIM) begin
      rec_nxt_s = IDLE_LIM;
    end else begin
      rec_nxt_s = rec_cnt_r + 4'd1;
    end
  end

  assign idle_hit_s = (rec_nxt_s == IDLE_LIM);

  // Frame tracking FSM; every output is registered with the bit it describes
  always_ff @(posedge SP or posedge reset) begin
    if (reset) begin
      state_r   <= ST_WAIT;
      rec_cnt_r <= 4'd0;
      run_len_r <= 3'd0;
      fix_cnt_r <= 3'd0;
      last_r    <= 1'b1;
      RX_D      <= 1'b1;
      STF_BIT   <= 1'b0;
      STF_ERR   <= 1'b0;
      BUS_IDLE  <= 1'b0;
      SOF       <= 1'b0;
      STF_CNT   <= 3'd0;
    end else begin
      rec_cnt_r <= rec_nxt_s;
      RX_D      <= RX;
      SOF       <= 1'b0;
      STF_BIT   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (RX) begin
            BUS_IDLE <= 1'b1;
          end else begin
            SOF       <= 1'b1;
            BUS_IDLE  <= 1'b0;
            state_r   <= ST_DYN;
            last_r    <= 1'b0;
            run_len_r <= 3'd1;
            STF_CNT   <= 3'd0;
            STF_ERR   <= 1'b0;
          end
        end
        ST_DYN: begin
          BUS_IDLE <= 1'b0;
          if (STF_END) begin
            state_r <= ST_OFF;
          end else if (FIX_STF) begin
            // First fixed stuff bit; a dynamic stuff bit due here is not counted
            if (RX == last_r) begin
              STF_ERR <= 1'b1;
              state_r <= ST_ERR;
            end else begin
              STF_BIT   <= 1'b1;
              fix_cnt_r <= 3'd0;
              last_r    <= RX;
              state_r   <= ST_FIX;
            end
          end else if (run_len_r == RUN_LIM) begin
            if (RX == last_r) begin
              STF_ERR <= 1'b1;
              state_r <= ST_ERR;
            end else begin
              STF_BIT   <= 1'b1;
              STF_CNT   <= STF_CNT + 3'd1;
              run_len_r <= 3'd1;
              last_r    <= RX;
            end
          end else begin
            run_len_r <= (RX == last_r) ? run_len_r + 3'd1 : 3'd1;
            last_r    <= RX;
          end
        end
        ST_FIX: begin
          BUS_IDLE <= 1'b0;
          if (STF_END) begin
            state_r <= ST_OFF;
          end else if (fix_cnt_r != FIX_LIM) begin
            fix_cnt_r <= fix_cnt_r + 3'd1;
            last_r    <= RX;
          end else if (RX == last_r) begin
            STF_ERR <= 1'b1;
            state_r <= ST_ERR;
          end else begin
            STF_BIT   <= 1'b1;
            fix_cnt_r <= 3'd0;
            last_r    <= RX;
          end
        end
        ST_ERR: begin
          BUS_IDLE <= idle_hit_s;
          STF_ERR  <= ~idle_hit_s;
          state_r  <= idle_hit_s ? ST_IDLE : ST_ERR;
        end
        ST_WAIT, ST_OFF: begin
          BUS_IDLE <= idle_hit_s;
          state_r  <= idle_hit_s ? ST_IDLE : state_r;
        end
        default: begin
          BUS_IDLE <= 1'b0;
          state_r  <= ST_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Bench for can_bit_destuffer: directed vector table, reset corner sequence and
// random frames checked against a bit-history reference model.
module tb_can_bit_destuffer;

  localparam int IDLE_BITS  = 11;
  localparam int STF_RUN    = 5;
  localparam int FIX_PERIOD = 4;

  localparam int M_WAIT = 0;
  localparam int M_IDLE = 1;
  localparam int M_DYN  = 2;
  localparam int M_FIX  = 3;
  localparam int M_OFF  = 4;
  localparam int M_ERR  = 5;

  logic       SP = 1'b0;
  logic       reset;
  logic       RX;
  logic       STF_END;
  logic       FIX_STF;
  logic       RX_D;
  logic       STF_BIT;
  logic       STF_ERR;
  logic       BUS_IDLE;
  logic       SOF;
  logic [2:0] STF_CNT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rx, se, fs, stf, err, idle, sof;
    int   cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: frame bits since SOF, recessive run, mode, total stuff count
  int   m_mode;
  int   m_ones;
  int   m_total;
  int   m_fixpos;
  logic m_frame[$];
  logic e_stf, e_err, e_idle, e_sof;
  logic gen_last;

  always #5 SP = ~SP;

  can_bit_destuffer #(.IDLE_BITS(IDLE_BITS), .STF_RUN(STF_RUN), .FIX_PERIOD(FIX_PERIOD)) dut (
    .SP(SP), .reset(reset), .RX(RX), .STF_END(STF_END), .FIX_STF(FIX_STF),
    .RX_D(RX_D), .STF_BIT(STF_BIT), .STF_ERR(STF_ERR), .BUS_IDLE(BUS_IDLE),
    .SOF(SOF), .STF_CNT(STF_CNT)
  );

  function automatic void add(logic rx, logic se, logic fs, logic stf, logic err,
                              logic idle, logic sof, int cnt);
    vec_t v;
    v.rx = rx; v.se = se; v.fs = fs; v.stf = stf; v.err = err;
    v.idle = idle; v.sof = sof; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic rxd, logic stf, logic err, logic idle,
                         logic sof, int cnt);
    chk({tag, " RX_D"}, int'(RX_D), int'(rxd));
    chk({tag, " STF_BIT"}, int'(STF_BIT), int'(stf));
    chk({tag, " STF_ERR"}, int'(STF_ERR), int'(err));
    chk({tag, " BUS_IDLE"}, int'(BUS_IDLE), int'(idle));
    chk({tag, " SOF"}, int'(SOF), int'(sof));
    chk({tag, " STF_CNT"}, int'(STF_CNT), cnt);
  endtask

  task automatic step(input logic rx, input logic se, input logic fs);
    RX = rx; STF_END = se; FIX_STF = fs;
    @(posedge SP);
    #1;
  endtask

  task automatic do_reset(string tag);
    reset = 1'b1;
    #2;
    chk_out({tag, " async"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(posedge SP);
    #1;
    chk_out({tag, " held"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
  endtask

  function automatic void model_reset();
    m_mode = M_WAIT; m_ones = 0; m_total = 0; m_fixpos = 0;
    e_err = 1'b0; m_frame.delete(); gen_last = 1'b1;
  endfunction

  // A dynamic stuff bit is due when the last STF_RUN frame bits are all equal
  function automatic bit frame_due();
    int n = m_frame.size();
    if (n < STF_RUN) return 1'b0;
    for (int i = 1; i < STF_RUN; i++)
      if (m_frame[n-1-i] != m_frame[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_bad();
    e_err = 1'b1;
    m_mode = M_ERR;
  endfunction

  function automatic void model_step(logic rx, logic se, logic fs);
    e_sof = 1'b0; e_stf = 1'b0; e_idle = 1'b0;
    m_ones = rx ? m_ones + 1 : 0;
    case (m_mode)
      M_IDLE: begin
        if (rx) e_idle = 1'b1;
        else begin
          e_sof = 1'b1; m_mode = M_DYN; m_total = 0; e_err = 1'b0;
          m_frame.delete(); m_frame.push_back(1'b0);
        end
      end
      M_DYN: begin
        if (se) m_mode = M_OFF;
        else if (fs) begin
          if (rx == m_frame[$]) model_bad();
          else begin e_stf = 1'b1; m_mode = M_FIX; m_fixpos = 0; end
        end else if (frame_due()) begin
          if (rx == m_frame[$]) model_bad();
          else begin e_stf = 1'b1; m_total++; end
        end
        m_frame.push_back(rx);
      end
      M_FIX: begin
        if (se) m_mode = M_OFF;
        else begin
          m_fixpos++;
          if (m_fixpos % (FIX_PERIOD + 1) == 0) begin
            if (rx == m_frame[$]) model_bad();
            else e_stf = 1'b1;
          end
        end
        m_frame.push_back(rx);
      end
      default: begin
        if (m_ones >= IDLE_BITS) begin
          m_mode = M_IDLE; e_idle = 1'b1; e_err = 1'b0;
        end
      end
    endcase
  endfunction

  function automatic logic gen_flip(int odds);
    return ($urandom_range(0, odds - 1) == 0) ? gen_last : ~gen_last;
  endfunction

  function automatic logic gen_dyn();
    if (m_mode == M_DYN && frame_due()) return gen_flip(15);
    return ($urandom_range(0, 2) != 0) ? gen_last : ~gen_last;
  endfunction

  task automatic rstep(input logic rx, input logic se, input logic fs);
    step(rx, se, fs);
    model_step(rx, se, fs);
    gen_last = rx;
    chk_out("rand", rx, e_stf, e_err, e_idle, e_sof, m_total % 8);
  endtask

  initial begin
    logic v;
    int   nbody;
    int   nfix;

    // Idle detection, SOF, dynamic stuffing and count wrap
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 2);
    for (int k = 3; k <= 9; k++) begin
      v = (k % 2 == 1) ? 1'b0 : 1'b1;
      for (int i = 0; i < 4; i++) add(v, 0, 0, 0, 0, 0, 0, (k - 1) % 8);
      add(~v, 0, 0, 1, 0, 0, 0, k % 8);
    end
    // Fixed stuffing, then a fixed stuff bit equal to its predecessor
    add(0, 0, 1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1); add(1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1); add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0, 1);
    // Sixth equal recessive bit is a stuff error, held until idle
    add(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    // STF_END overrides a due stuff bit; ACK then ten recessive is not yet idle
    add(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    // FIX_STF on a due dynamic stuff bit leaves the count alone
    add(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);

    reset = 1'b1; RX = 1'b1; STF_END = 1'b0; FIX_STF = 1'b0;
    #12;
    chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rx, vecs[i].se, vecs[i].fs);
      chk_out($sformatf("vec%0d", i), vecs[i].rx, vecs[i].stf, vecs[i].err,
              vecs[i].idle, vecs[i].sof, vecs[i].cnt);
    end

    // Reset mid-frame, then a dominant bit before idle must not be an SOF
    step(0, 0, 0);
    chk("midrst SOF", int'(SOF), 1);
    step(0, 0, 0);
    step(1, 0, 0);
    do_reset("midrst");
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      chk("post-reset BUS_IDLE", int'(BUS_IDLE), 0);
    end
    step(0, 0, 0);
    chk("early dominant SOF", int'(SOF), 0);
    chk("early dominant BUS_IDLE", int'(BUS_IDLE), 0);
    for (int i = 0; i < IDLE_BITS; i++) step(1, 0, 0);
    chk("re-idle BUS_IDLE", int'(BUS_IDLE), 1);
    step(0, 0, 0);
    chk("re-idle SOF", int'(SOF), 1);

    // Random frames against the reference model
    do_reset("rand reset");
    model_reset();
    for (int f = 0; f < 60; f++) begin
      repeat ($urandom_range(8, 13)) rstep(1'b1, 1'b0, 1'b0);
      rstep(1'b0, 1'b0, 1'b0);
      nbody = $urandom_range(8, 40);
      for (int b = 0; b < nbody; b++) begin
        if (f % 16 == 9 && b == 5) begin
          do_reset("rand midframe");
          model_reset();
        end
        rstep(gen_dyn(), 1'b0, 1'b0);
      end
      if ($urandom_range(0, 1) == 1) begin
        rstep(gen_flip(12), 1'b0, 1'b1);
        nfix = $urandom_range(4, 16);
        for (int b = 1; b <= nfix; b++)
          rstep((b % (FIX_PERIOD + 1) == 0) ? gen_flip(12) : 1'($urandom_range(0, 1)),
                1'b0, 1'b0);
      end
      rstep(1'b1, 1'b1, 1'b0);
      rstep(($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
